// File: rtl/ppu_scroll_if.sv
// CPU register bus, renderer strobes and VRAM address/data for the PPU scroll block.
// The PPU block drives the slave side; the CPU/renderer/VRAM environment drives the master side.
interface ppu_scroll_if;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        render_en;
  logic        inc32;
  logic        rend;
  logic        inc_cx;
  logic        inc_y;
  logic        return00;
  logic        fetch_attr;
  logic        fetch_chr;
  logic [12:0] pattern_idx;
  logic [7:0]  data_i;
  logic [13:0] vaddr;
  logic [2:0]  fine_x;
  logic [1:0]  attr_i;
  logic [14:0] v_dbg;

  modport slave (
    input  reg_wr, reg_rd, reg_addr, reg_data, render_en, inc32, rend,
           inc_cx, inc_y, return00, fetch_attr, fetch_chr, pattern_idx, data_i,
    output vaddr, fine_x, attr_i, v_dbg
  );

  modport master (
    output reg_wr, reg_rd, reg_addr, reg_data, render_en, inc32, rend,
           inc_cx, inc_y, return00, fetch_attr, fetch_chr, pattern_idx, data_i,
    input  vaddr, fine_x, attr_i, v_dbg
  );
endinterface

// File: rtl/ppu_scroll.sv
// PPU scroll/address state (v, t, fine_x, w): CPU register decode, renderer
// scroll increments/copies, VRAM address mux and attribute bit selection.
module ppu_scroll #(
  parameter logic [13:0] NT_BASE   = 14'h2000,
  parameter logic [9:0]  AT_OFFSET = 10'h3C0
) (
  input logic         clk,
  input logic         rst,
  ppu_scroll_if.slave bus
);

  logic [14:0] v_q, v_d, t_q, t_d;
  logic [2:0]  fx_q, fx_d, at_sh_q, at_sh_d;
  logic        w_q, w_d, hcopy_q, hcopy_d;

  logic active;
  logic wr2000, wr2005, wr2006, rd2002, acc2007;

  assign active  = bus.render_en & bus.rend;
  assign wr2000  = bus.reg_wr && (bus.reg_addr == 3'd0);
  assign wr2005  = bus.reg_wr && (bus.reg_addr == 3'd5);
  assign wr2006  = bus.reg_wr && (bus.reg_addr == 3'd6);
  assign rd2002  = bus.reg_rd && (bus.reg_addr == 3'd2);
  // $2007 traffic bumps v only outside rendering, where the renderer owns v
  assign acc2007 = (bus.reg_wr || bus.reg_rd) && (bus.reg_addr == 3'd7) && !active;

  always_comb begin
    t_d  = t_q;
    fx_d = fx_q;
    w_d  = w_q;
    if (wr2000) t_d[11:10] = bus.reg_data[1:0];
    if (wr2005) begin
      if (!w_q) begin
        t_d[4:0] = bus.reg_data[7:3];
        fx_d     = bus.reg_data[2:0];
        w_d      = 1'b1;
      end else begin
        t_d[14:12] = bus.reg_data[2:0];
        t_d[9:5]   = bus.reg_data[7:3];
        w_d        = 1'b0;
      end
    end
    if (wr2006) begin
      if (!w_q) begin
        t_d[13:8] = bus.reg_data[5:0];
        t_d[14]   = 1'b0;
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = bus.reg_data;
        w_d      = 1'b0;
      end
    end
    if (rd2002) w_d = 1'b0;
  end

  // Updates are layered lowest priority first so higher ones overwrite only their own fields.
  always_comb begin
    v_d = v_q;
    if (active && bus.inc_cx) begin
      if (v_q[4:0] == 5'd31) begin
        v_d[4:0] = 5'd0;
        v_d[10]  = ~v_q[10];
      end else begin
        v_d[4:0] = v_q[4:0] + 5'd1;
      end
    end
    if (active && bus.inc_y) begin
      if (v_q[14:12] != 3'd7) begin
        v_d[14:12] = v_q[14:12] + 3'd1;
      end else begin
        v_d[14:12] = 3'd0;
        if (v_q[9:5] == 5'd29) begin
          v_d[9:5] = 5'd0;
          v_d[11]  = ~v_q[11];
        end else if (v_q[9:5] == 5'd31) begin
          v_d[9:5] = 5'd0;
        end else begin
          v_d[9:5] = v_q[9:5] + 5'd1;
        end
      end
    end
    if (hcopy_q) begin
      v_d[10]  = t_q[10];
      v_d[4:0] = t_q[4:0];
    end
    if (active && bus.return00) begin
      v_d[14:11] = t_q[14:11];
      v_d[9:5]   = t_q[9:5];
    end
    if (acc2007) v_d = v_q + (bus.inc32 ? 15'd32 : 15'd1);
    if (wr2006 && w_q) v_d = {t_q[14:8], bus.reg_data};
  end

  assign hcopy_d = active & bus.inc_y;
  // Quadrant select within the attribute byte: coarse Y bit 1 picks the nibble, coarse X bit 1 the pair
  assign at_sh_d = (active && bus.fetch_attr) ? {v_q[6], v_q[1], 1'b0} : at_sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      t_q     <= '0;
      fx_q    <= '0;
      w_q     <= 1'b0;
      hcopy_q <= 1'b0;
      at_sh_q <= '0;
    end else begin
      v_q     <= v_d;
      t_q     <= t_d;
      fx_q    <= fx_d;
      w_q     <= w_d;
      hcopy_q <= hcopy_d;
      at_sh_q <= at_sh_d;
    end
  end

  always_comb begin
    if (active && bus.fetch_chr)
      bus.vaddr = {1'b0, bus.pattern_idx};
    else if (active && bus.fetch_attr)
      bus.vaddr = NT_BASE | {4'b0, AT_OFFSET} | {2'b0, v_q[11:10], 4'b0, v_q[9:7], v_q[4:2]};
    else if (active)
      bus.vaddr = NT_BASE | {2'b0, v_q[11:0]};
    else
      bus.vaddr = v_q[13:0];
  end

  assign bus.fine_x = fx_q;
  assign bus.attr_i = bus.data_i[at_sh_q +: 2];
  assign bus.v_dbg  = v_q;

endmodule
